// File: rtl/fix_point_mac.sv
// Streaming fixed-point multiply-accumulate: multiplies operand pairs and sums the
// products with symmetric saturation, presenting the dot product once per vector.

module mult_fix_point #(
  parameter int Q = 12,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  localparam logic signed [2*N-1:0] P_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] P_MIN = -P_MAX;

  logic signed [2*N-1:0] full;
  logic signed [2*N-1:0] shifted;

  // Full-width product rescaled back to Q format, clamped to the symmetric range
  always_comb begin
    full    = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    shifted = full >>> Q;
    p       = shifted[N-1:0];
    if (shifted > P_MAX) begin
      p = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < P_MIN) begin
      p = {1'b1, {(N-2){1'b0}}, 1'b1};
    end
  end

endmodule

module fix_point_mac #(
  parameter int Q     = 12,
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_HOLD} state_t;

  localparam logic signed [N:0] SUM_MAX = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] SUM_MIN = -SUM_MAX;
  localparam logic [N-1:0]      SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]      SAT_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [N-1:0]      prod_q, prod_d;
  logic              prod_v_q, prod_v_d;
  logic              prod_last_q, prod_last_d;
  logic [N-1:0]      acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_valid_q, out_valid_d;

  logic [N-1:0]      mult_p;
  logic              accept;
  logic signed [N:0] sum;
  logic [N-1:0]      acc_sat;
  logic              step_ovf;

  mult_fix_point #(.Q(Q), .N(N)) u_mult (
    .a (in_a),
    .b (in_b),
    .p (mult_p)
  );

  assign in_ready  = (state_q == ST_ACC);
  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    prod_v_d    = accept;
    prod_last_d = prod_last_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    sum      = $signed({acc_q[N-1], acc_q}) + $signed({prod_q[N-1], prod_q});
    acc_sat  = sum[N-1:0];
    step_ovf = 1'b0;
    if (sum > SUM_MAX) begin
      acc_sat  = SAT_POS;
      step_ovf = 1'b1;
    end else if (sum < SUM_MIN) begin
      acc_sat  = SAT_NEG;
      step_ovf = 1'b1;
    end

    if (accept) begin
      prod_d      = mult_p;
      prod_last_d = in_last;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (prod_v_q) begin
      acc_d = acc_sat;
      ovf_d = ovf_q | step_ovf;
    end

    case (state_q)
      ST_ACC: begin
        if (accept && in_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The flagged last product is in stage 1 now; capture it into the result
        if (prod_v_q && prod_last_q) begin
          out_data_d  = acc_sat;
          out_ovf_d   = ovf_q | step_ovf;
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          cnt_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      prod_last_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      prod_last_q <= prod_last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fix_point_mac.sv
// Directed bench for fix_point_mac: hand-computed dot products, saturation,
// back-pressure, ready gating, mid-vector reset and the zero-product case.

module tb_fix_point_mac;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [15:0] out_count;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  fix_point_mac #(.Q(12), .N(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one pair from a negedge and returns on the negedge after it is taken
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic last);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] data,
                               input logic ovf, input logic [15:0] count);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_output({tag, "_data"}, out_data, data);
    check_output({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    check_output({tag, "_count"}, {16'd0, out_count}, {16'd0, count});
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_count", {16'd0, out_count}, 32'd0);
    check_output("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

    // 2.0 + (1.5 * -1.0) = 0.5, with the consumer stalling for three cycles
    apply_stimulus(32'h0000_1000, 32'h0000_2000, 1'b0);
    apply_stimulus(32'h0000_1800, 32'hFFFF_F000, 1'b1);
    in_valid = 1'b0;
    check_output("bp_flush_valid", {31'd0, out_valid}, 32'd0);
    check_output("bp_flush_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_output("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    check_output("bp_data", out_data, 32'h0000_0800);
    check_output("bp_count", {16'd0, out_count}, 32'd2);
    check_output("bp_ovf", {31'd0, out_ovf}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_output("bp_hold_data", out_data, 32'h0000_0800);
      check_output("bp_hold_count", {16'd0, out_count}, 32'd2);
      check_output("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_output("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // 256.0 squared is 65536.0; the eighth addition crosses 2^31
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h0010_0000, 32'h0010_0000, i == 7);
    end
    in_valid = 1'b0;
    expect_result("pos_sat", 32'h7FFF_FFFF, 1'b1, 16'd8);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(32'h0010_0000, 32'hFFF0_0000, i == 7);
    end
    in_valid = 1'b0;
    expect_result("neg_sat", 32'h8000_0001, 1'b1, 16'd8);

    apply_stimulus(32'h0000_1000, 32'h0000_1000, 1'b1);
    in_valid = 1'b0;
    expect_result("cleared", 32'h0000_1000, 1'b0, 16'd1);

    // in_valid stays high through FLUSH/HOLD; the held pair becomes the next vector
    out_ready = 1'b0;
    apply_stimulus(32'h0000_1000, 32'h0000_1000, 1'b0);
    apply_stimulus(32'h0000_1000, 32'h0000_2000, 1'b1);
    in_b = 32'h0000_3000;
    check_output("gate_flush_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_output("gate_hold_ready", {31'd0, in_ready}, 32'd0);
    check_output("gate_valid", {31'd0, out_valid}, 32'd1);
    check_output("gate_data", out_data, 32'h0000_3000);
    check_output("gate_count", {16'd0, out_count}, 32'd2);
    @(negedge clk);
    check_output("gate_hold2_ready", {31'd0, in_ready}, 32'd0);
    check_output("gate_hold2_count", {16'd0, out_count}, 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    check_output("gate_return_ready", {31'd0, in_ready}, 32'd1);
    check_output("gate_return_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    expect_result("gate_next", 32'h0000_3000, 1'b0, 16'd1);

    // Partial vector discarded by reset
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h0000_1000, 32'h0000_1000, 1'b0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_output("midrst_count", {16'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(32'h0000_2000, 32'h0000_1000, 1'b1);
    in_valid = 1'b0;
    expect_result("midrst", 32'h0000_2000, 1'b0, 16'd1);

    apply_stimulus(32'h0000_0000, 32'h8000_0000, 1'b1);
    in_valid = 1'b0;
    expect_result("zero", 32'h0000_0000, 1'b0, 16'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
